// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART baud generator.
//
// Contents:
//   C_OVERSAMPLE_MIN/MAX  legal oversample range (4..32)
//   div_t                 divisor struct {div_int, div_frac} at maximum widths
//   default_div*()        elaboration-time reset divisor:
//                         C_SYSTEM_FREQ / (C_BAUDRATE * C_OVERSAMPLE) as an
//                         integer part plus an fw-bit fraction rounded to nearest.
package uart_pkg;

  localparam int unsigned C_OVERSAMPLE_MIN = 4;
  localparam int unsigned C_OVERSAMPLE_MAX = 32;

  typedef struct packed {
    logic [31:0] div_int;
    logic [15:0] div_frac;
  } div_t;

  // Divisor as a fixed-point value with fw fractional bits, rounded to nearest.
  // A fraction that rounds up to 1.0 carries into the integer part naturally.
  function automatic longint unsigned div_fixed(input longint unsigned sys_freq,
                                                input longint unsigned baud,
                                                input longint unsigned os,
                                                input int unsigned     fw);
    longint unsigned den;
    den = baud * os;
    return ((sys_freq << fw) + (den / 2)) / den;
  endfunction

  function automatic logic [31:0] default_div_int(input longint unsigned sys_freq,
                                                  input longint unsigned baud,
                                                  input longint unsigned os,
                                                  input int unsigned     fw);
    return 32'(div_fixed(sys_freq, baud, os, fw) >> fw);
  endfunction

  function automatic logic [15:0] default_div_frac(input longint unsigned sys_freq,
                                                   input longint unsigned baud,
                                                   input longint unsigned os,
                                                   input int unsigned     fw);
    return 16'(div_fixed(sys_freq, baud, os, fw) & ((64'd1 << fw) - 64'd1));
  endfunction

  function automatic div_t default_div(input longint unsigned sys_freq,
                                       input longint unsigned baud,
                                       input longint unsigned os,
                                       input int unsigned     fw);
    div_t d;
    d.div_int  = default_div_int(sys_freq, baud, os, fw);
    d.div_frac = default_div_frac(sys_freq, baud, os, fw);
    return d;
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// uart_frac_acc -- fractional divisor accumulator for uart_baud_gen.
//
// Adds frac once per oversample period (step). The carry out is held in ext
// for the whole following period, lengthening it by one clock.
//
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   clr          clear accumulator and ext (has priority over step)
//   step         oversample period boundary
//   frac         fractional divisor, units of 2^-C_FRAC_WIDTH cycle
//   ext          1 = current period is one cycle longer
module uart_frac_acc
  import uart_pkg::*;
#(
  parameter int unsigned C_FRAC_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clr,
  input  logic                    step,
  input  logic [C_FRAC_WIDTH-1:0] frac,
  output logic                    ext
);

  logic [C_FRAC_WIDTH-1:0] acc_q;
  logic [C_FRAC_WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, frac};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      ext   <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      ext   <= 1'b0;
    end else if (step) begin
      acc_q <= sum[C_FRAC_WIDTH-1:0];
      ext   <= sum[C_FRAC_WIDTH];
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- fractional-N oversample / baud tick generator.
//
// A cycle counter runs 0..P-1 with P = div_int (min 2), plus one cycle when
// the fractional accumulator carried at the previous period boundary.
// os_tick is registered: it is high in the cycle after the counter hits P-1.
// bit_phase counts os_ticks modulo C_OVERSAMPLE; baud_tick marks the os_tick
// that wraps bit_phase to 0.
//
// Configuration macro: UART_BAUD_FRAC_EN
//   defined   -> fractional accumulator (uart_frac_acc) is built in
//   undefined -> P = div_int always, cfg_div_frac and reset fraction ignored
//
// Divisor handshake: a divisor transfers on a clock edge where
// cfg_valid && cfg_ready. cfg_ready stays low while that divisor is pending;
// it is applied at the next period boundary (or next cycle if en is low) and
// cfg_ready returns high the cycle after application.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   en                 generator enable; low holds counters at 0
//   cfg_valid/ready    divisor handshake
//   cfg_div_int        integer clk cycles per oversample tick (0,1 act as 2)
//   cfg_div_frac       fractional part, units of 2^-C_FRAC_WIDTH cycle
//   rx_resync          realign bit phase to an RX start edge
//   os_tick            one-cycle oversample pulse
//   baud_tick          one-cycle bit-period pulse
//   bit_phase          oversample index within the bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned C_SYSTEM_FREQ = 50_000_000,
  parameter int unsigned C_BAUDRATE    = 115200,
  parameter int unsigned C_OVERSAMPLE  = 16,
  parameter int unsigned C_DIV_WIDTH   = 16,
  parameter int unsigned C_FRAC_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            en,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [C_DIV_WIDTH-1:0]          cfg_div_int,
  input  logic [C_FRAC_WIDTH-1:0]         cfg_div_frac,
  input  logic                            rx_resync,
  output logic                            os_tick,
  output logic                            baud_tick,
  output logic [$clog2(C_OVERSAMPLE)-1:0] bit_phase
);

  localparam int unsigned PH_W = $clog2(C_OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(C_OVERSAMPLE - 1);
  localparam div_t DEF = default_div(C_SYSTEM_FREQ, C_BAUDRATE, C_OVERSAMPLE, C_FRAC_WIDTH);
  localparam logic [C_DIV_WIDTH-1:0] DEF_INT = C_DIV_WIDTH'(DEF.div_int);

  logic [C_DIV_WIDTH-1:0] div_int_q;
  logic [C_DIV_WIDTH-1:0] pend_int_q;
  logic                   pending_q;
  logic [C_DIV_WIDTH-1:0] cnt_q;
  logic                   os_tick_q;
  logic                   baud_tick_q;
  logic [PH_W-1:0]        phase_q;

  logic                   ext;
  logic [C_DIV_WIDTH-1:0] div_eff;
  logic [C_DIV_WIDTH-1:0] last_cnt;
  logic                   wrap;
  logic                   apply;
  logic                   accept;
  logic                   phase_last;

  // div 0/1 would allow back-to-back ticks; clamp so ticks are always spaced.
  assign div_eff    = (div_int_q < C_DIV_WIDTH'(2)) ? C_DIV_WIDTH'(2) : div_int_q;
  assign last_cnt   = div_eff - C_DIV_WIDTH'(1) + C_DIV_WIDTH'(ext);
  // Resync wins over a tick that falls due in the same cycle.
  assign wrap       = en && !rx_resync && (cnt_q == last_cnt);
  assign apply      = pending_q && (!en || wrap);
  assign accept     = cfg_valid && !pending_q;
  assign phase_last = (phase_q == PH_LAST);

  assign cfg_ready  = !pending_q;
  assign os_tick    = os_tick_q;
  assign baud_tick  = baud_tick_q;
  assign bit_phase  = phase_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      phase_q     <= '0;
    end else begin
      os_tick_q   <= wrap;
      baud_tick_q <= wrap && phase_last;
      if (!en || rx_resync || wrap) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + C_DIV_WIDTH'(1);
      end
      if (!en || rx_resync) begin
        phase_q <= '0;
      end else if (wrap) begin
        phase_q <= phase_last ? '0 : phase_q + PH_W'(1);
      end
    end
  end

  // Divisor register and single-entry pending slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_int_q  <= DEF_INT;
      pend_int_q <= '0;
      pending_q  <= 1'b0;
    end else if (apply) begin
      div_int_q  <= pend_int_q;
      pending_q  <= 1'b0;
    end else if (accept) begin
      pend_int_q <= cfg_div_int;
      pending_q  <= 1'b1;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  localparam logic [C_FRAC_WIDTH-1:0] DEF_FRAC = C_FRAC_WIDTH'(DEF.div_frac);

  logic [C_FRAC_WIDTH-1:0] div_frac_q;
  logic [C_FRAC_WIDTH-1:0] pend_frac_q;
  logic                    acc_clr;

  // Accumulator restarts whenever the period grid restarts or the divisor changes.
  assign acc_clr = !en || rx_resync || apply;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_frac_q  <= DEF_FRAC;
      pend_frac_q <= '0;
    end else if (apply) begin
      div_frac_q  <= pend_frac_q;
    end else if (accept) begin
      pend_frac_q <= cfg_div_frac;
    end
  end

  uart_frac_acc #(
    .C_FRAC_WIDTH(C_FRAC_WIDTH)
  ) u_frac_acc (
    .clk    (clk),
    .resetn (resetn),
    .clr    (acc_clr),
    .step   (wrap),
    .frac   (div_frac_q),
    .ext    (ext)
  );
`else
  logic unused_frac;
  assign unused_frac = ^cfg_div_frac;
  assign ext         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen -- self-checking bench for uart_baud_gen (default parameters).
//
// The reference model tracks the absolute clock edge at which the next
// os_tick is due, a tick count modulo the oversample factor, an integer
// fractional accumulator and a one-deep pending-divisor slot. Every driven
// cycle pushes the expected {cfg_ready, baud_tick, os_tick, bit_phase} into
// exp_q and the sampled outputs are compared against it.
// Handshake: a divisor transfers on an edge where cfg_valid && cfg_ready.
module tb_uart_baud_gen;

  localparam int     OS   = 16;
  localparam int     DW   = 16;
  localparam int     FW   = 4;
  localparam int     PW   = 4;
  localparam longint SYS  = 50_000_000;
  localparam longint BAUD = 115200;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_div_int = '0;
  logic [FW-1:0] cfg_div_frac = '0;
  logic          rx_resync = 1'b0;
  logic          os_tick;
  logic          baud_tick;
  logic [PW-1:0] bit_phase;

  always #5 clk = ~clk;

  uart_baud_gen dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .rx_resync    (rx_resync),
    .os_tick      (os_tick),
    .baud_tick    (baud_tick),
    .bit_phase    (bit_phase)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [6:0]  exp_q[$];
  longint      tick_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint tgap(input int a, input int b);
    if (tick_q.size() > b) return tick_q[b] - tick_q[a];
    return -1;
  endfunction

  // ---------------- reference model ----------------
  int     def_int, def_frac;
  int     m_div, m_frac, m_pdiv, m_pfrac, m_acc, m_ext, m_phase;
  bit     m_pend, m_running;
  longint m_due;
  longint n = 0;   // index of the next clock edge

  function automatic int peff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    longint den, q;
    den      = BAUD * OS;
    q        = (SYS * (1 << FW) + den / 2) / den;
    def_int  = int'(q / (1 << FW));
    def_frac = int'(q % (1 << FW));
    m_div    = def_int;
    m_frac   = def_frac;
    m_pend   = 0;
    m_acc    = 0;
    m_ext    = 0;
    m_phase  = 0;
    m_running = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit e, input bit rs, input bit cv,
                            input int di, input int df, output logic [6:0] ex);
    bit ot, bt, pend_before;
    ot = 0;
    bt = 0;
    pend_before = m_pend;
    if (!e) begin
      m_running = 0;
      m_acc = 0;
      m_ext = 0;
      m_phase = 0;
      if (pend_before) begin
        m_div = m_pdiv;
        m_frac = m_pfrac;
        m_pend = 0;
      end
    end else if (rs) begin
      m_running = 1;
      m_acc = 0;
      m_ext = 0;
      m_phase = 0;
      m_due = n + peff(m_div);
    end else begin
      if (!m_running) begin
        m_running = 1;
        m_due = n + peff(m_div) - 1;
      end
      if (n == m_due) begin
        ot = 1;
        m_phase = (m_phase + 1) % OS;
        bt = (m_phase == 0);
        if (pend_before) begin
          m_div = m_pdiv;
          m_frac = m_pfrac;
          m_pend = 0;
          m_acc = 0;
          m_ext = 0;
        end else if (FRAC_ON) begin
          m_acc = m_acc + m_frac;
          m_ext = (m_acc >= (1 << FW)) ? 1 : 0;
          m_acc = m_acc % (1 << FW);
        end
        m_due = n + peff(m_div) + m_ext;
      end
    end
    if (cv && !pend_before) begin
      m_pend = 1;
      m_pdiv = di;
      m_pfrac = df;
    end
    ex = {~m_pend, bt, ot, 4'(m_phase)};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit e, input bit rs, input bit cv, input int di, input int df);
    logic [6:0] ex;
    @(negedge clk);
    en           = e;
    rx_resync    = rs;
    cfg_valid    = cv;
    cfg_div_int  = DW'(di);
    cfg_div_frac = FW'(df);
    model_step(e, rs, cv, di, df, ex);
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    check("cfg_ready", cfg_ready, ex[6]);
    check("baud_tick", baud_tick, ex[5]);
    check("os_tick", os_tick, ex[4]);
    check("bit_phase", bit_phase, ex[3:0]);
    if (os_tick) tick_q.push_back(n);
    n++;
  endtask

  task automatic idle(input int cycles, input bit e);
    for (int i = 0; i < cycles; i++) drive_cycle(e, 1'b0, 1'b0, 0, 0);
  endtask

  // Offer a divisor (en high) and wait, bounded, until cfg_ready returns.
  task automatic cfg_and_wait(input int di, input int df, output int low);
    drive_cycle(1'b1, 1'b0, 1'b1, di, df);
    low = 0;
    while (cfg_ready !== 1'b1 && low < 100) begin
      low++;
      drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
    end
    check("cfg_timeout", (low < 100), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int     low;
    longint r_edge, e_edge;
    longint span;
    int     k;

    model_reset();
    #1 resetn = 1'b0;
    #1;
    check("rst_os_tick", os_tick, 0);
    check("rst_baud_tick", baud_tick, 0);
    check("rst_bit_phase", bit_phase, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    #6 resetn = 1'b1;

    // Default divisor, free running.
    tick_q.delete();
    idle(600, 1'b1);
    check("n_ticks_ge17", (tick_q.size() >= 17), 1);
    span = tgap(0, 16);
`ifdef UART_BAUD_FRAC_EN
    check("span16_frac", (span == 434 || span == 435), 1);
`else
    check("span16_int", span, 432);
`endif

    // New divisor while running: old period completes, then every 10 cycles.
    cfg_and_wait(10, 0, low);
    check("ready_low_range", (low >= 1 && low <= 28), 1);
    tick_q.delete();
    idle(45, 1'b1);
    check("p10_gap0", tgap(0, 1), 10);
    check("p10_gap1", tgap(1, 2), 10);

    // div_int 1 and 0 both behave as 2.
    cfg_and_wait(1, 0, low);
    tick_q.delete();
    idle(12, 1'b1);
    check("div1_gap", tgap(0, 1), 2);
    check("div1_gap2", tgap(2, 3), 2);
    cfg_and_wait(0, 0, low);
    tick_q.delete();
    idle(12, 1'b1);
    check("div0_gap", tgap(0, 1), 2);

    // rx_resync on the cycle a tick is due.
    cfg_and_wait(7, 0, low);
    k = 0;
    while (m_due != n && k < 50) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
      k++;
    end
    check("rs_due_reached", (k < 50), 1);
    r_edge = n;
    drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
    check("rs_no_tick", os_tick, 0);
    check("rs_phase0", bit_phase, 0);
    tick_q.delete();
    idle(20, 1'b1);
    check("rs_next_tick", tgap(0, 0) == 0 ? tick_q[0] - r_edge : -1, 7);

    // en low for 50 cycles with a divisor accepted in the middle.
    tick_q.delete();
    for (int i = 0; i < 50; i++) drive_cycle(1'b0, 1'b0, (i == 10), 9, 0);
    check("en_low_ticks", tick_q.size(), 0);
    check("en_low_ready", cfg_ready, 1);
    e_edge = n;
    idle(30, 1'b1);
    check("en_first_tick", (tick_q.size() > 0) ? tick_q[0] - (e_edge - 1) : -1, 9);

    // div_int 10 with frac 8.
    cfg_and_wait(10, 8, low);
    tick_q.delete();
    idle(120, 1'b1);
`ifdef UART_BAUD_FRAC_EN
    check("frac8_span8", tgap(0, 8), 84);
    check("frac8_gap0", tgap(0, 1), 10);
    check("frac8_gap1", tgap(1, 2), 11);
`else
    check("nofrac_span8", tgap(0, 8), 80);
    check("nofrac_gap1", tgap(1, 2), 10);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom_range(0, 99) < 95), ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 12), $urandom_range(0, 15));
    end

    // Async reset with a divisor pending.
    idle(3, 1'b0);
    cfg_and_wait(10, 0, low);
    idle(2, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1, 5, 3);
    check("pend_before_rst", cfg_ready, 0);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_os_tick", os_tick, 0);
    check("mid_rst_baud_tick", baud_tick, 0);
    check("mid_rst_bit_phase", bit_phase, 0);
    check("mid_rst_cfg_ready", cfg_ready, 1);
    #1 resetn = 1'b1;
    model_reset();
    tick_q.delete();
    idle(120, 1'b1);
    check("post_rst_first", (tick_q.size() > 0) ? tick_q[0] - (tick_q[0] - tgap(0, 0)) : -1, 0);
    check("post_rst_gap", tgap(0, 1), 27);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 Parameter C_SYSTEM_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 Parameter C_BAUDRATE, default 115200, baud rate loaded at reset.
REQ-003 Parameter C_OVERSAMPLE, default 16, oversample ticks per bit; legal range 4..32.
REQ-004 Parameter C_DIV_WIDTH, default 16, integer divisor width.
REQ-005 Parameter C_FRAC_WIDTH, default 4, fractional divisor width.
REQ-006 clk  in  1  system clock.
REQ-007 resetn  in  1  reset, asynchronous, active-low.
REQ-008 en  in  1  generator enable.
REQ-009 cfg_valid  in  1  new divisor offered.
REQ-010 cfg_ready  out  1  divisor register free to accept.
REQ-011 cfg_div_int  in  C_DIV_WIDTH  integer clk cycles per oversample tick.
REQ-012 cfg_div_frac  in  C_FRAC_WIDTH  fractional part, units of 2^-C_FRAC_WIDTH cycle.
REQ-013 rx_resync  in  1  RX start-edge pulse; realigns bit phase.
REQ-014 os_tick  out  1  one-cycle oversample pulse for RX sampling.
REQ-015 baud_tick  out  1  one-cycle bit-period pulse for TX.
REQ-016 bit_phase  out  $clog2(C_OVERSAMPLE)  current oversample index within bit.

Function
REQ-017 Cycle counter counts 0..P-1, where P = div_int, or div_int+1 when fractional accumulator carries; os_tick asserts, registered, in the cycle after the counter reaches P-1.
REQ-018 Fractional accumulator (C_FRAC_WIDTH bits) adds div_frac once per oversample period; carry-out extends the next period by exactly one cycle.
REQ-019 Effective div_int values 0 and 1 are treated as 2; os_tick never asserts on consecutive cycles.
REQ-020 bit_phase increments on each os_tick, wraps C_OVERSAMPLE-1 -> 0; baud_tick asserts coincident with the os_tick that wraps bit_phase.
REQ-021 rx_resync clears cycle counter, accumulator and bit_phase; a tick due in the same cycle is suppressed (resync wins).
REQ-022 en low: counters held at 0, os_tick/baud_tick 0; first os_tick occurs P cycles after en rises.
REQ-023 cfg handshake: transfer on cfg_valid && cfg_ready; cfg_ready drops the following cycle while a divisor is pending.
REQ-024 Pending divisor applies at the next oversample-period boundary (counter reload), or on the next cycle when en is low; cfg_ready re-asserts the cycle after application.
REQ-025 Accumulator clears when a new divisor is applied; bit_phase is preserved.
REQ-026 Reset mid-operation aborts any pending divisor and reloads defaults.

Reset
REQ-027 Async reset: os_tick=0, baud_tick=0, bit_phase=0, cfg_ready=1, counters=0.
REQ-028 Reset divisor = C_SYSTEM_FREQ/(C_BAUDRATE*C_OVERSAMPLE), integer and fractional parts computed at elaboration, fraction rounded to nearest.

Configuration
REQ-029 Macro UART_BAUD_FRAC_EN defined: fractional accumulator present per REQ-018.
REQ-030 Macro UART_BAUD_FRAC_EN undefined: no accumulator, cfg_div_frac ignored, P = div_int always, reset fraction discarded.

Structure
REQ-031 Package uart_pkg holds default-divisor constant functions, C_OVERSAMPLE bounds and the divisor struct (int, frac).
REQ-032 One sub-module uart_frac_acc (accumulator + carry), instantiated only under UART_BAUD_FRAC_EN.

Verification
REQ-033 Reset defaults, 50 MHz/115200/16x -> div_int=27, frac=2; 16 os_ticks span 434 or 435 cycles; baud_tick every 16th.
REQ-034 cfg div_int=10, frac=0 while running -> old period completes, then os_tick every 10 cycles; cfg_ready low 1..P cycles.
REQ-035 div_int=1 -> os_tick every 2 cycles; div_int=0 -> same.
REQ-036 rx_resync on the cycle a tick is due -> no os_tick that cycle, bit_phase=0, next os_tick P cycles later.
REQ-037 en low for 50 cycles, cfg accepted during it -> no ticks, new divisor applied next cycle, first os_tick P cycles after en rises.
REQ-038 UART_BAUD_FRAC_EN undefined, frac=8, div_int=10 -> every period exactly 10 cycles.
